hazard_ctrl: RTL and testbench

- Pipeline control unit that reads the EXE-side outputs of the ID/EXE pipeline register and the ID-stage source operands.
- Generates the stall, bubble, flush and redirect controls that drive the PC, IF/ID and ID/EXE registers.
- Handles two cases: load-use hazards and taken branches resolved in EXE.
- Sits beside the decode stage and is consumed by the pipeline registers and the PC mux.

---
 rtl/hazard_ctrl_pkg.sv | 28 ++
 rtl/hazard_cmp.sv | 25 ++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, FSM encoding and output bundle for the hazard unit.
// Imported by hazard_cmp and hazard_ctrl.
package hazard_ctrl_pkg;

  localparam int DSIZE = 32;
  localparam int ASIZE = 5;
  localparam int ISIZE = 32;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    LDS = 2'd1,
    BRF = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_bubble;
    logic pc_redirect;
  } hz_ctl_t;

  // Remaining cycles after the detect cycle; callers only use n > 1.
  function automatic logic [2:0] cnt_init(input int unsigned n);
    return 3'(n - 1);
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: EXE load writing a register that ID reads.
// Ports: ID sources/uses, EXE dest/wen/memtoreg in; lu out.
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [ASIZE-1:0] raddr1,
  input  logic [ASIZE-1:0] raddr2,
  input  logic             use1,
  input  logic             use2,
  input  logic [ASIZE-1:0] waddr,
  input  logic             wen,
  input  logic             memtoreg,
  output logic             lu
);

  logic hit1;
  logic hit2;

  assign hit1 = use1 & (raddr1 == waddr);
  assign hit2 = use2 & (raddr2 == waddr);

  // x0 is hardwired, so a load targeting it never blocks a reader.
  assign lu = memtoreg & wen & (waddr != '0) & (hit1 | hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush control for PC, IF/ID, ID/EXE.
// Ports: clk, rst (async, active low), ID/EXE hazard inputs in;
// stall/flush/bubble/redirect + pc_target out.
// HAZARD_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LD_STALL   = 1,
  parameter int unsigned BR_PENALTY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] id_raddr1,
  input  logic [ASIZE-1:0] id_raddr2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             ex_wen,
  input  logic             ex_memtoreg,
  input  logic             ex_branch,
  input  logic             ex_br_taken,
  input  logic [ISIZE-1:0] ex_br_target,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pc_redirect,
  output logic [ISIZE-1:0] pc_target
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  hz_state_t  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  hz_ctl_t    ctl;
  logic       br;
  logic       lu;

  assign br = ex_branch & ex_br_taken;

  hazard_cmp u_cmp (
    .raddr1   (id_raddr1),
    .raddr2   (id_raddr2),
    .use1     (id_use1),
    .use2     (id_use2),
    .waddr    (ex_waddr),
    .wen      (ex_wen),
    .memtoreg (ex_memtoreg),
    .lu       (lu)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl     = '0;
    if (rst) begin
      unique case (state_q)
        RUN, LDS: begin
          if (br) begin
            // Branch squashes whatever was stalled behind it.
            ctl.pc_redirect = 1'b1;
            ctl.ifid_flush  = 1'b1;
            ctl.idex_bubble = 1'b1;
            if (BR_PENALTY > 1) begin
              state_d = BRF;
              cnt_d   = cnt_init(BR_PENALTY);
            end else begin
              state_d = RUN;
              cnt_d   = '0;
            end
          end else if (state_q == LDS) begin
            ctl.pc_stall    = 1'b1;
            ctl.ifid_stall  = 1'b1;
            ctl.idex_bubble = 1'b1;
            cnt_d           = cnt_q - 3'd1;
            if (cnt_q == 3'd1)
              state_d = RUN;
          end else if (lu) begin
            ctl.pc_stall    = 1'b1;
            ctl.ifid_stall  = 1'b1;
            ctl.idex_bubble = 1'b1;
            if (LD_STALL > 1) begin
              state_d = LDS;
              cnt_d   = cnt_init(LD_STALL);
            end
          end
        end
        BRF: begin
          // EXE holds only bubbles here; hazard inputs are ignored.
          ctl.ifid_flush  = 1'b1;
          ctl.idex_bubble = 1'b1;
          cnt_d           = cnt_q - 3'd1;
          if (cnt_q == 3'd1)
            state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pc_stall    = ctl.pc_stall;
  assign ifid_stall  = ctl.ifid_stall & ~ctl.ifid_flush;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_bubble = ctl.idex_bubble;
  assign pc_redirect = ctl.pc_redirect;
  assign pc_target   = ctl.pc_redirect ? ex_br_target : '0;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (pc_redirect && flush_cnt != '1)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two parameterisations share stimulus.
// Expected outputs come from a cycle-count model of the hazard rules.
module tb_hazard_ctrl;

  typedef struct packed {
    logic        stall;
    logic        istall;
    logic        flush;
    logic        bubble;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_raddr1 = '0, id_raddr2 = '0, ex_waddr = '0;
  logic        id_use1 = 0, id_use2 = 0, ex_wen = 0, ex_memtoreg = 0;
  logic        ex_branch = 0, ex_br_taken = 0;
  logic [31:0] ex_br_target = '0;

  logic        a_ps, a_is, a_fl, a_bb, a_rd;
  logic [31:0] a_tg;
  logic        b_ps, b_is, b_fl, b_bb, b_rd;
  logic [31:0] b_tg;
  logic [31:0] a_sc, a_fc, b_sc, b_fc;

  int vectors = 0;
  int miscompares = 0;

  exp_t q [2][$];

  // Model state: cycles of stall/flush still owed after the current one.
  int rem_st [2] = '{0, 0};
  int rem_fl [2] = '{0, 0};
  longint cnt_s [2] = '{0, 0};
  longint cnt_f [2] = '{0, 0};
  int ldp [2] = '{1, 3};
  int brp [2] = '{1, 2};

  always #5 clk = ~clk;

  hazard_ctrl #(.LD_STALL(1), .BR_PENALTY(1)) dut_a (
    .clk(clk), .rst(rst),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .id_use1(id_use1), .id_use2(id_use2),
    .ex_waddr(ex_waddr), .ex_wen(ex_wen), .ex_memtoreg(ex_memtoreg),
    .ex_branch(ex_branch), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target),
    .pc_stall(a_ps), .ifid_stall(a_is), .ifid_flush(a_fl),
    .idex_bubble(a_bb), .pc_redirect(a_rd), .pc_target(a_tg)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(a_sc), .flush_cnt(a_fc)
`endif
  );

  hazard_ctrl #(.LD_STALL(3), .BR_PENALTY(2)) dut_b (
    .clk(clk), .rst(rst),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .id_use1(id_use1), .id_use2(id_use2),
    .ex_waddr(ex_waddr), .ex_wen(ex_wen), .ex_memtoreg(ex_memtoreg),
    .ex_branch(ex_branch), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target),
    .pc_stall(b_ps), .ifid_stall(b_is), .ifid_flush(b_fl),
    .idex_bubble(b_bb), .pc_redirect(b_rd), .pc_target(b_tg)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(b_sc), .flush_cnt(b_fc)
`endif
  );

`ifndef HAZARD_PERF_EN
  assign a_sc = '0;
  assign a_fc = '0;
  assign b_sc = '0;
  assign b_fc = '0;
`endif

  task automatic predict(input int k, output exp_t e);
    bit br, lu;
    e = '0;
    br = ex_branch && ex_br_taken;
    lu = ex_memtoreg && ex_wen && ex_waddr != 0 &&
         ((id_use1 && id_raddr1 == ex_waddr) ||
          (id_use2 && id_raddr2 == ex_waddr));
    if (!rst) begin
      rem_st[k] = 0; rem_fl[k] = 0;
      cnt_s[k] = 0;  cnt_f[k] = 0;
    end else begin
`ifdef HAZARD_PERF_EN
      e.sc = 32'(cnt_s[k]);
      e.fc = 32'(cnt_f[k]);
`endif
      if (rem_fl[k] > 0) begin
        e.flush = 1; e.bubble = 1;
        rem_fl[k]--;
      end else if (br) begin
        e.redir = 1; e.flush = 1; e.bubble = 1;
        e.tgt = ex_br_target;
        rem_fl[k] = brp[k] - 1;
        rem_st[k] = 0;
      end else if (rem_st[k] > 0) begin
        e.stall = 1; e.istall = 1; e.bubble = 1;
        rem_st[k]--;
      end else if (lu) begin
        e.stall = 1; e.istall = 1; e.bubble = 1;
        rem_st[k] = ldp[k] - 1;
      end
      if (e.stall && cnt_s[k] < 64'hFFFF_FFFF) cnt_s[k]++;
      if (e.redir && cnt_f[k] < 64'hFFFF_FFFF) cnt_f[k]++;
    end
  endtask

  task automatic step(input logic r, input logic bn, input logic tk,
                      input logic [31:0] tg, input logic mem,
                      input logic wn, input logic [4:0] wa,
                      input logic u1, input logic [4:0] r1,
                      input logic u2, input logic [4:0] r2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_branch = bn; ex_br_taken = tk; ex_br_target = tg;
    ex_memtoreg = mem; ex_wen = wn; ex_waddr = wa;
    id_use1 = u1; id_raddr1 = r1; id_use2 = u2; id_raddr2 = r2;
    for (int k = 0; k < 2; k++) begin
      predict(k, e);
      q[k].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    for (int k = 0; k < 2; k++) begin
      if (q[k].size() > 0) begin
        e = q[k].pop_front();
        if (k == 0)
          a = '{a_ps, a_is, a_fl, a_bb, a_rd, a_tg, a_sc, a_fc};
        else
          a = '{b_ps, b_is, b_fl, b_bb, b_rd, b_tg, b_sc, b_fc};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL dut%0d t=%0t got %h want %h", k, $time, a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with branch and load-use both asserted.
    repeat (3) step(0, 1, 1, 32'h40, 1, 1, 5, 1, 5, 0, 0);
    step(1, 1, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Load-use on x5, then the same against x0.
    step(1, 0, 0, 0, 1, 1, 5, 1, 5, 0, 0);
    idle(4);
    step(1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    idle(2);
    // Load-use via raddr2, branch arriving in the 2nd stall cycle.
    step(1, 0, 0, 0, 1, 1, 7, 0, 0, 1, 7);
    step(1, 1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // Taken branch, then a not-taken one.
    step(1, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Simultaneous branch and load-use.
    step(1, 1, 1, 32'hC0, 1, 1, 3, 1, 3, 1, 3);
    idle(3);
    // Load-use, then reset mid-flush after a branch.
    step(1, 0, 0, 0, 1, 1, 2, 1, 2, 0, 0);
    idle(2);
    step(1, 1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Random traffic on a small register space for frequent hits.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0),
           $urandom,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)));
    end
    idle(2);
    @(posedge clk);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (q[k].size() != 0) begin
        miscompares++;
        $display("FAIL drain dut%0d got %0d pending want 0",
                 k, q[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
